// File: rtl/d_clock_pkg.sv
// Shared constants for the clock display driver: digit indices, segment codes, slot states.
package d_clock_pkg;

    localparam int NUM_DIGITS = 6;

    localparam int DIG_SEC1  = 0;
    localparam int DIG_SEC2  = 1;
    localparam int DIG_MIN1  = 2;
    localparam int DIG_MIN2  = 3;
    localparam int DIG_HOUR1 = 4;
    localparam int DIG_HOUR2 = 5;

    // Active-high codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_DRIVE = 1'b1
    } slot_state_e;

endpackage

// File: rtl/d_clock_disp_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-BCD values show a dash.
module bcd_to_seg
    import d_clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/d_clock_disp.sv
// Six-digit multiplexed seven-segment driver with per-frame snapshot and guard interval.
// Optional HOUR_LZB_EN: blanks the hour tens digit when it is zero.
module d_clock_disp
    import d_clock_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2,
    parameter int ACT_LOW  = 1
) (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic [3:0] sec_1,
    input  logic [2:0] sec_2,
    input  logic [3:0] min_1,
    input  logic [2:0] min_2,
    input  logic [3:0] hour_1,
    input  logic [1:0] hour_2,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int   PW  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic POL = (ACT_LOW != 0);

    logic [PW-1:0]                   presc_reg, presc_next, presc_inc;
    logic [2:0]                      idx_reg, idx_next;
    slot_state_e                     state_reg, state_next;
    logic                            load_reg;
    logic [NUM_DIGITS-1:0][3:0]      raw_digit;
    logic [NUM_DIGITS-1:0][3:0]      shadow_reg;
    logic [3:0]                      digit_sel;
    logic [6:0]                      seg_code;
    logic [NUM_DIGITS-1:0]           an_drive;
    logic                            slot_end, frame_end, snap, blank_h2;
    logic [6:0]                      seg_reg;
    logic [5:0]                      an_reg;
    logic                            frame_done_reg;

    assign raw_digit[DIG_SEC1]  = sec_1;
    assign raw_digit[DIG_SEC2]  = {1'b0, sec_2};
    assign raw_digit[DIG_MIN1]  = min_1;
    assign raw_digit[DIG_MIN2]  = {1'b0, min_2};
    assign raw_digit[DIG_HOUR1] = hour_1;
    assign raw_digit[DIG_HOUR2] = {2'b00, hour_2};

    assign presc_inc = presc_reg + 1'b1;
    assign slot_end  = (presc_reg == PW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_reg == 3'(DIG_HOUR2));
    // The first edge after reset behaves like a frame boundary so a valid snapshot exists.
    assign snap      = load_reg || frame_end;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
            state_reg <= SLOT_GUARD;
            load_reg  <= 1'b1;
        end else begin
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            state_reg <= state_next;
            load_reg  <= 1'b0;
        end
    end

    always_comb begin
        presc_next = presc_inc;
        idx_next   = idx_reg;
        state_next = state_reg;
        if (load_reg) begin
            presc_next = '0;
            idx_next   = '0;
            state_next = SLOT_GUARD;
        end else if (slot_end) begin
            presc_next = '0;
            idx_next   = (idx_reg == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
            state_next = SLOT_GUARD;
        end else begin
            case (state_reg)
                SLOT_GUARD: if (presc_inc == PW'(GUARD)) state_next = SLOT_DRIVE;
                SLOT_DRIVE: state_next = SLOT_DRIVE;
                default:    state_next = SLOT_GUARD;
            endcase
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if (snap) begin
            shadow_reg <= raw_digit;
        end
    end

    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == 3'(i)) digit_sel = shadow_reg[i];
        end
    end

    bcd_to_seg u_dec (
        .bcd (digit_sel),
        .seg (seg_code)
    );

`ifdef HOUR_LZB_EN
    assign blank_h2 = (shadow_reg[DIG_HOUR2] == 4'd0);
`else
    assign blank_h2 = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
        if (gi == DIG_HOUR2) begin : g_h2
            assign an_drive[gi] = (state_reg == SLOT_DRIVE) && (idx_reg == 3'(gi)) && !blank_h2;
        end else begin : g_oth
            assign an_drive[gi] = (state_reg == SLOT_DRIVE) && (idx_reg == 3'(gi));
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg        <= {7{POL}};
            an_reg         <= {6{POL}};
            frame_done_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_code ^ {7{POL}};
            an_reg         <= an_drive ^ {6{POL}};
            frame_done_reg <= frame_end;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_d_clock_disp.sv
// Frame-level bench for d_clock_disp: active-low and active-high instances scanned side by side.
module tb_d_clock_disp;

    localparam int NF = 6;

    localparam logic [6:0] K0 = 7'b0111111;
    localparam logic [6:0] K1 = 7'b0000110;
    localparam logic [6:0] K2 = 7'b1011011;
    localparam logic [6:0] K3 = 7'b1001111;
    localparam logic [6:0] K4 = 7'b1100110;
    localparam logic [6:0] K5 = 7'b1101101;
    localparam logic [6:0] K6 = 7'b1111101;
    localparam logic [6:0] K7 = 7'b0000111;
    localparam logic [6:0] K8 = 7'b1111111;
    localparam logic [6:0] K9 = 7'b1101111;
    localparam logic [6:0] KD = 7'b1000000;

    typedef struct {
        logic [3:0]      s1;
        logic [2:0]      s2;
        logic [3:0]      m1;
        logic [2:0]      m2;
        logic [3:0]      h1;
        logic [1:0]      h2;
        logic [5:0][6:0] code;
    } frame_t;

    typedef struct packed {
        logic [6:0] seg;
        logic [5:0] an;
        logic       fd;
    } exp_t;

    logic       clk_1 = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec_1 = '0;
    logic [2:0] sec_2 = '0;
    logic [3:0] min_1 = '0;
    logic [2:0] min_2 = '0;
    logic [3:0] hour_1 = '0;
    logic [1:0] hour_2 = '0;
    logic [6:0] seg_lo, seg_hi;
    logic [5:0] an_lo, an_hi;
    logic       fd_lo, fd_hi;

    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    frame_t tbl[NF];

    always #5 clk_1 = ~clk_1;

    d_clock_disp #(.SCAN_DIV(4), .GUARD(1), .ACT_LOW(1)) dut_lo (
        .clk_1(clk_1), .rst_n(rst_n),
        .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
        .hour_1(hour_1), .hour_2(hour_2),
        .seg(seg_lo), .an(an_lo), .frame_done(fd_lo)
    );

    d_clock_disp #(.SCAN_DIV(4), .GUARD(1), .ACT_LOW(0)) dut_hi (
        .clk_1(clk_1), .rst_n(rst_n),
        .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
        .hour_1(hour_1), .hour_2(hour_2),
        .seg(seg_hi), .an(an_hi), .frame_done(fd_hi)
    );

    function automatic frame_t mk(input logic [3:0] s1, input logic [2:0] s2,
                                  input logic [3:0] m1, input logic [2:0] m2,
                                  input logic [3:0] h1, input logic [1:0] h2,
                                  input logic [6:0] c0, input logic [6:0] c1,
                                  input logic [6:0] c2, input logic [6:0] c3,
                                  input logic [6:0] c4, input logic [6:0] c5);
        frame_t f;
        f.s1 = s1; f.s2 = s2; f.m1 = m1; f.m2 = m2; f.h1 = h1; f.h2 = h2;
        f.code[0] = c0; f.code[1] = c1; f.code[2] = c2;
        f.code[3] = c3; f.code[4] = c4; f.code[5] = c5;
        return f;
    endfunction

    // Drive a frame's inputs and queue the 24 output cycles it should produce.
    task automatic drive_frame(input frame_t f);
        exp_t e;
        sec_1 = f.s1; sec_2 = f.s2; min_1 = f.m1; min_2 = f.m2;
        hour_1 = f.h1; hour_2 = f.h2;
        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < 4; j++) begin
                e.seg = f.code[s];
                e.an  = (j == 0) ? 6'b000000 : 6'(1 << s);
`ifdef HOUR_LZB_EN
                if (s == 5 && f.h2 == 2'd0) e.an = 6'b000000;
`endif
                e.fd  = (s == 5 && j == 3);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                     name, act[13:7], act[6:1], act[0], req[13:7], req[6:1], req[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        tbl[0] = mk(4'd6, 3'd5, 4'd4, 4'd3 - 1'b0, 4'd2, 2'd1, K6, K5, K4, K3, K2, K1);
        tbl[1] = mk(4'd6, 3'd5, 4'd7, 3'd3, 4'd2, 2'd1, K6, K5, K7, K3, K2, K1);
        tbl[2] = mk(4'hC, 3'd5, 4'd7, 3'd3, 4'd2, 2'd1, KD, K5, K7, K3, K2, K1);
        tbl[3] = mk(4'd9, 3'd5, 4'd9, 3'd5, 4'd3, 2'd2, K9, K5, K9, K5, K3, K2);
        tbl[4] = mk(4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 2'd0, K0, K0, K0, K0, K0, K0);
        tbl[5] = mk(4'd8, 3'd4, 4'd8, 3'd0, 4'd8, 2'd1, K8, K4, K8, K0, K8, K1);

        rst_n = 1'b0;
        drive_frame(tbl[0]);
        repeat (5) @(negedge clk_1);
        check("reset_lo", {seg_lo, an_lo, fd_lo}, {7'h7F, 6'h3F, 1'b0});
        check("reset_hi", {seg_hi, an_hi, fd_hi}, {7'h00, 6'h00, 1'b0});
        rst_n = 1'b1;
        @(negedge clk_1);

        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < 24; c++) begin
                @(negedge clk_1);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: frame=%0d cyc=%0d got nothing queued, want an entry", f, c);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("scan_lo f%0d c%0d", f, c), {seg_lo, an_lo, fd_lo},
                          {~e.seg, ~e.an, e.fd});
                    check($sformatf("scan_hi f%0d c%0d", f, c), {seg_hi, an_hi, fd_hi},
                          {e.seg, e.an, e.fd});
                end
                // Inputs for the next frame change mid-frame (slot 1) to prove snapshot isolation.
                if (c == 5 && f + 1 < NF) drive_frame(tbl[f+1]);
            end
        end

        // Frame 6 repeats frame 5 inputs; reset asynchronously while slot 0 is driving.
        @(posedge clk_1);
        @(posedge clk_1);
        #2;
        check("pre_areset_lo", {seg_lo, an_lo, fd_lo}, {~K8, 6'b111110, 1'b0});
        check("pre_areset_hi", {seg_hi, an_hi, fd_hi}, {K8, 6'b000001, 1'b0});
        rst_n = 1'b0;
        #1;
        check("areset_lo", {seg_lo, an_lo, fd_lo}, {7'h7F, 6'h3F, 1'b0});
        check("areset_hi", {seg_hi, an_hi, fd_hi}, {7'h00, 6'h00, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_clock_disp.md
Name: d_clock_disp

Overview:
Multiplexed six-digit seven-segment display driver for the digital clock's BCD time outputs (sec_1..hour_2).
Takes a snapshot of the six digits once per frame and scans one digit per slot. Drives registered segment and digit-enable lines with a ghosting guard interval.
Sits between the clock counter and the board's common-anode/cathode display.

Parameters:
SCAN_DIV, 1000, clk_1 cycles per digit slot (>= 2)
GUARD, 2, cycles at slot start with all digits disabled (1 <= GUARD < SCAN_DIV)
ACT_LOW, 1, 1: seg/an active-low; 0: active-high

Ports:
clk_1  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
sec_1  input  4  seconds units, BCD
sec_2  input  3  seconds tens
min_1  input  4  minutes units, BCD
min_2  input  3  minutes tens
hour_1  input  4  hours units, BCD
hour_2  input  2  hours tens
seg  output  7  segments {g,f,e,d,c,b,a}, registered
an  output  6  one-hot digit enables; bit 0 = sec_1, bit 5 = hour_2; registered
frame_done  output  1  one-cycle pulse at the end of slot 5

Behaviour:
- Interface: one clock, clk_1; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0): prescaler=0, idx=0, state=GUARD, shadow digits=0, frame_done=0.
- Reset outputs: seg and an at the inactive level (all 1 if ACT_LOW, else all 0).
- Reset mid-frame aborts the scan immediately.
- First rising edge after release: load the snapshot from the inputs and start slot 0 in GUARD.
- Prescaler: counts 0..SCAN_DIV-1 within each slot. The terminal count ends the slot.
- idx: advances 0..5 at each slot end and wraps 5 -> 0.
- Per-slot FSM:
  - GUARD (prescaler < GUARD): an inactive; seg is loaded with the code of the new digit.
  - DRIVE (GUARD <= prescaler <= SCAN_DIV-1): an[idx] active, other enables inactive; seg holds the code.
  - GUARD -> DRIVE when prescaler reaches GUARD.
  - DRIVE -> GUARD at the slot end.
- Outputs are registered: an/seg reflect a state one cycle after it is entered.
- Snapshot: all six inputs are sampled into shadow registers only on the slot-5-end edge, which is also the edge where idx wraps to 0.
  - Input changes mid-frame are invisible until the next frame, so no tearing.
- frame_done: high for exactly the cycle after the slot-5-end edge. Period = 6*SCAN_DIV cycles.
- Decode: narrow digits are zero-extended to 4 bits.
  - 0-9 map to standard codes (active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Values 10-15 display a dash, 1000000.
- Polarity: if ACT_LOW, seg and an are bitwise inverted at the output register.

Optional Feature:
Macro HOUR_LZB_EN: leading-zero blanking of hour_2.
- Defined: if the shadow hour_2 == 0, an[5] stays inactive for the whole of slot 5. seg still cycles normally and the slot timing is unchanged.
- Undefined: slot 5 displays "0" when hour_2 == 0.

Decomposition:
- Package d_clock_pkg:
  - NUM_DIGITS=6
  - digit index constants DIG_SEC1..DIG_HOUR2 (0..5)
  - SEG_0..SEG_9 and SEG_DASH 7-bit codes
  - 1-bit slot-state encoding GUARD/DRIVE
- Sub-module bcd_to_seg: purely combinational, 4-bit in -> 7-bit active-high code, dash for values above 9. It is instantiated once, on the idx-muxed shadow digit.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with ACT_LOW=1 -> seg=7'h7F, an=6'h3F, frame_done=0. Assert rst_n=0 asynchronously mid-slot -> outputs go inactive without waiting for a clock edge.
- Scan order, SCAN_DIV=4, GUARD=1, inputs 12:34:56:
  - expected digits sec_1..hour_2 = 6,5,4,3,2,1 (slots 0..5)
  - slot 0 (sec_1=6): an=6'b111110 active for 3 of 4 cycles, seg=~7'b1111101
  - frame_done pulses every 24 cycles.
- Snapshot integrity: change min_1 from 4 to 7 during slot 1 -> slot 2 of the current frame still shows 4. The next frame shows 7 (seg=~7'b0000111).
- Invalid BCD: sec_1=4'hC -> slot 0 seg=~7'b1000000 (dash).
- Boundary values: inputs 23:59:59 then 00:00:00 on a frame boundary -> the frame before shows 2,3,5,9,5,9; the frame after shows all zeros. With HOUR_LZB_EN defined, an[5] stays 1 (inactive) throughout slot 5.
- Polarity: ACT_LOW=0, digit 8 -> seg=7'b1111111, an one-hot high. Guard cycles show an=6'b000000.
